// File: rtl/spram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : spram_arb_pkg
//  Description : Shared grant encoding and default widths for the SPRAM
//                arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package spram_arb_pkg;

  // 2-bit grant encoding shared by the picker and the top-level mux
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IM   = 2'd1;
  localparam logic [1:0] GNT_DM   = 2'd2;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;

endpackage : spram_arb_pkg
`default_nettype wire

// File: rtl/spram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : spram_arbiter_if
//  Description : Fetch port, data port and SPRAM-side signals of the arbiter.
//                slave = arbiter view, master = core/RAM environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spram_arbiter_if
  import spram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  // instruction-fetch port
  logic                  im_ren;
  logic [ADDR_W-1:0]     im_addr;
  logic [DATA_W-1:0]     im_rdata;
  logic                  im_miss;
  // data port
  logic                  dm_ren;
  logic [DATA_W/8-1:0]   dm_ben;
  logic [ADDR_W-1:0]     dm_addr;
  logic [DATA_W-1:0]     dm_wdata;
  logic [DATA_W-1:0]     dm_rdata;
  logic                  dm_miss;
  // SPRAM side
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_ben;
  logic                  mem_wen;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  im_ren, im_addr, dm_ren, dm_ben, dm_addr, dm_wdata, mem_rdata,
    output im_rdata, im_miss, dm_rdata, dm_miss,
           mem_addr, mem_wdata, mem_ben, mem_wen
  );

  modport master (
    output im_ren, im_addr, dm_ren, dm_ben, dm_addr, dm_wdata, mem_rdata,
    input  im_rdata, im_miss, dm_rdata, dm_miss,
           mem_addr, mem_wdata, mem_ben, mem_wen
  );

endinterface : spram_arbiter_if
`default_nettype wire

// File: rtl/spram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way picker between fetch (IM) and data (DM). On a
//                conflict DM wins when DM_PRIORITY is set, otherwise the
//                requester that was not granted last wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import spram_arb_pkg::*;
#(
  parameter int DM_PRIORITY = 0
) (
  input  wire logic       clk,
  input  wire logic       reset,    // asynchronous, active-low
  input  wire logic       elig_im,
  input  wire logic       elig_dm,
  output logic [1:0]      gnt
);

  logic [1:0] r_last_gnt;
  logic       w_conflict_dm;

  // conflict resolution fixed at elaboration: fixed DM priority or alternation
  if (DM_PRIORITY != 0) begin : g_dm_fixed
    assign w_conflict_dm = 1'b1;
  end else begin : g_round_robin
    assign w_conflict_dm = (r_last_gnt != GNT_DM);
  end

  // at most one grant per cycle
  always_comb begin
    gnt = GNT_NONE;
    if (elig_im && elig_dm) begin
      gnt = w_conflict_dm ? GNT_DM : GNT_IM;
    end else if (elig_im) begin
      gnt = GNT_IM;
    end else if (elig_dm) begin
      gnt = GNT_DM;
    end
  end

  // remember the most recent winner; reset to IM so the first conflict goes to DM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_gnt <= GNT_IM;
    end else if (gnt != GNT_NONE) begin
      r_last_gnt <= gnt;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/spram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spram_arbiter
//  Description : Shares one single-port SPRAM between the instruction-fetch
//                and data ports. Access granted in cycle C: address issued in
//                C, read data captured at the end of C+1, ack (miss=0) in C+2.
//  Revision    : 1.0 - initial release
// ============================================================================
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DM_PRIORITY = 0
) (
  input  wire logic        clk,
  input  wire logic        reset,   // asynchronous, active-low
  spram_arbiter_if.slave   bus
);

  localparam int BEN_W = DATA_W / 8;

  logic              w_imreq, w_dmreq, w_dm_wr;
  logic              w_elig_im, w_elig_dm;
  logic [1:0]        w_gnt;
  logic              r_run;
  logic              r_pend_im, r_pend_dm, r_pend_dm_wr;
  logic              r_ack_im, r_ack_dm;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_wdata_hold;
  logic [DATA_W-1:0] r_im_rdata, r_dm_rdata;

  assign w_imreq = bus.im_ren;
  assign w_dm_wr = |bus.dm_ben;
  assign w_dmreq = bus.dm_ren | w_dm_wr;

  // a requester with an access in flight or being acked is never re-granted;
  // r_run keeps grants off until the first edge after reset release
  assign w_elig_im = r_run & w_imreq & ~r_pend_im & ~r_ack_im;
  assign w_elig_dm = r_run & w_dmreq & ~r_pend_dm & ~r_ack_dm;

  rr_arb2 #(
    .DM_PRIORITY (DM_PRIORITY)
  ) u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .elig_im (w_elig_im),
    .elig_dm (w_elig_dm),
    .gnt     (w_gnt)
  );

  // drive the SPRAM from the winner; address/data hold when nothing is granted
  always_comb begin
    bus.mem_addr  = r_addr_hold;
    bus.mem_wdata = r_wdata_hold;
    bus.mem_ben   = '0;
    bus.mem_wen   = 1'b0;
    if (w_gnt == GNT_IM) begin
      bus.mem_addr = bus.im_addr;
    end else if (w_gnt == GNT_DM) begin
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
      bus.mem_ben   = bus.dm_ben;
      bus.mem_wen   = w_dm_wr;
    end
  end

  // grant bookkeeping: pend for the cycle after grant, ack the cycle after that
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run        <= 1'b0;
      r_pend_im    <= 1'b0;
      r_pend_dm    <= 1'b0;
      r_pend_dm_wr <= 1'b0;
      r_ack_im     <= 1'b0;
      r_ack_dm     <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_run        <= 1'b1;
      r_pend_im    <= (w_gnt == GNT_IM);
      r_pend_dm    <= (w_gnt == GNT_DM);
      r_pend_dm_wr <= (w_gnt == GNT_DM) && w_dm_wr;
      r_ack_im     <= r_pend_im;
      r_ack_dm     <= r_pend_dm;
      r_addr_hold  <= bus.mem_addr;
      r_wdata_hold <= bus.mem_wdata;
    end
  end

  // capture SPRAM read data one cycle after issue; writes leave dm_rdata alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_im_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (r_pend_im) begin
        r_im_rdata <= bus.mem_rdata;
      end
      if (r_pend_dm && !r_pend_dm_wr) begin
        r_dm_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.im_rdata = r_im_rdata;
  assign bus.dm_rdata = r_dm_rdata;
  assign bus.im_miss  = w_imreq & ~r_ack_im;
  assign bus.dm_miss  = w_dmreq & ~r_ack_dm;

endmodule : spram_arbiter
`default_nettype wire

// File: tb/tb_spram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spram_arbiter
//  Description : Directed self-checking bench. dut_rr uses round-robin
//                conflict resolution, dut_fx gives DM fixed priority; each
//                has a small SPRAM model with a one-cycle read latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spram_arbiter;
  import spram_arb_pkg::*;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // preload path into both RAM models (only used while the DUTs are idle)
  logic              pre_en   = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  spram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  spram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  spram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DM_PRIORITY(0)) dut_rr (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );
  spram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DM_PRIORITY(1)) dut_fx (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  // SPRAM models: byte-enabled write, registered read
  logic [DATA_W-1:0] ram0 [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram1 [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (pre_en) begin
      ram0[pre_addr] <= pre_data;
    end else if (bus0.mem_wen) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (bus0.mem_ben[b]) ram0[bus0.mem_addr][8*b +: 8] <= bus0.mem_wdata[8*b +: 8];
    end
    bus0.mem_rdata <= ram0[bus0.mem_addr];
  end

  always @(posedge clk) begin
    if (pre_en) begin
      ram1[pre_addr] <= pre_data;
    end else if (bus1.mem_wen) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (bus1.mem_ben[b]) ram1[bus1.mem_addr][8*b +: 8] <= bus1.mem_wdata[8*b +: 8];
    end
    bus1.mem_rdata <= ram1[bus1.mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one complete dm access on dut_rr with no competition; exp_rd is dm_rdata at ack
  task automatic dm_access(input string tag, input logic [3:0] ben, input logic [13:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd);
    bus0.dm_ren   = (ben == 4'b0);
    bus0.dm_ben   = ben;
    bus0.dm_addr  = addr;
    bus0.dm_wdata = wdata;
    #1;
    check({tag, " c0 mem_wen"},  bus0.mem_wen, (ben != 4'b0));
    check({tag, " c0 mem_addr"}, bus0.mem_addr, addr);
    check({tag, " c0 dm_miss"},  bus0.dm_miss, 1'b1);
    tick();
    check({tag, " c1 dm_miss"},  bus0.dm_miss, 1'b1);
    check({tag, " c1 mem_wen"},  bus0.mem_wen, 1'b0);
    tick();
    check({tag, " c2 dm_miss"},  bus0.dm_miss, 1'b0);
    check({tag, " c2 dm_rdata"}, bus0.dm_rdata, exp_rd);
    tick();
    bus0.dm_ren = 1'b0;
    bus0.dm_ben = 4'b0;
  endtask

  // expected per-cycle behaviour of dut_fx under continuous traffic
  logic [13:0] fx_addr [6] = '{14'h050, 14'h010, 14'h010, 14'h050, 14'h010, 14'h010};
  logic        fx_dm   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        fx_im   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.im_ren = 0; bus0.im_addr = '0; bus0.dm_ren = 0; bus0.dm_ben = '0;
    bus0.dm_addr = '0; bus0.dm_wdata = '0;
    bus1.im_ren = 0; bus1.im_addr = '0; bus1.dm_ren = 0; bus1.dm_ben = '0;
    bus1.dm_addr = '0; bus1.dm_wdata = '0;

    // ---- reset state ----
    tick(); tick();
    check("rst im_miss",  bus0.im_miss, 1'b0);
    check("rst dm_miss",  bus0.dm_miss, 1'b0);
    check("rst im_rdata", bus0.im_rdata, 32'h0);
    check("rst dm_rdata", bus0.dm_rdata, 32'h0);
    check("rst mem_addr", bus0.mem_addr, 14'h0);
    bus0.im_ren = 1; bus0.im_addr = 14'h010;
    #1;
    check("rst req im_miss",  bus0.im_miss, 1'b1);
    check("rst req mem_wen",  bus0.mem_wen, 1'b0);
    check("rst req mem_ben",  bus0.mem_ben, 4'h0);
    check("rst req mem_addr", bus0.mem_addr, 14'h0);
    bus0.im_ren = 0;

    // preload RAM contents
    pre_en = 1; pre_addr = 14'h010; pre_data = 32'h1234_5678; tick();
    pre_addr = 14'h030; pre_data = 32'hCAFE_0030; tick();
    pre_addr = 14'h050; pre_data = 32'h5050_A0A0; tick();
    pre_en = 0;
    reset = 1'b1;
    tick();

    // ---- im-only read ----
    bus0.im_ren = 1; bus0.im_addr = 14'h010; #1;
    check("im c0 mem_addr", bus0.mem_addr, 14'h010);
    check("im c0 im_miss",  bus0.im_miss, 1'b1);
    check("im c0 mem_wen",  bus0.mem_wen, 1'b0);
    tick();
    check("im c1 im_miss",  bus0.im_miss, 1'b1);
    tick();
    check("im c2 im_miss",  bus0.im_miss, 1'b0);
    check("im c2 im_rdata", bus0.im_rdata, 32'h1234_5678);
    bus0.im_ren = 0;
    tick();
    check("im c3 im_miss",  bus0.im_miss, 1'b0);

    // ---- first conflict: last grant IM, so DM first ----
    bus0.im_ren = 1; bus0.im_addr = 14'h050;
    bus0.dm_ren = 1; bus0.dm_addr = 14'h030; #1;
    check("cf1 c0 mem_addr", bus0.mem_addr, 14'h030);
    check("cf1 c0 im_miss",  bus0.im_miss, 1'b1);
    check("cf1 c0 dm_miss",  bus0.dm_miss, 1'b1);
    tick();
    check("cf1 c1 mem_addr", bus0.mem_addr, 14'h050);
    check("cf1 c1 dm_miss",  bus0.dm_miss, 1'b1);
    tick();
    check("cf1 c2 dm_miss",  bus0.dm_miss, 1'b0);
    check("cf1 c2 im_miss",  bus0.im_miss, 1'b1);
    check("cf1 c2 dm_rdata", bus0.dm_rdata, 32'hCAFE_0030);
    bus0.dm_ren = 0;
    tick();
    check("cf1 c3 im_miss",  bus0.im_miss, 1'b0);
    check("cf1 c3 im_rdata", bus0.im_rdata, 32'h5050_A0A0);
    bus0.im_ren = 0;
    tick();

    // ---- dm write, read, partial write, read ----
    dm_access("wr full", 4'b1111, 14'h020, 32'hDEAD_BEEF, 32'hCAFE_0030);
    dm_access("rd full", 4'b0000, 14'h020, 32'h0,         32'hDEAD_BEEF);
    dm_access("wr part", 4'b0001, 14'h020, 32'h0000_00AA, 32'hDEAD_BEEF);
    dm_access("rd part", 4'b0000, 14'h020, 32'h0,         32'hDEAD_BEAA);

    // ---- second conflict: last grant DM, so IM first ----
    bus0.im_ren = 1; bus0.im_addr = 14'h010;
    bus0.dm_ren = 1; bus0.dm_addr = 14'h030; #1;
    check("cf2 c0 mem_addr", bus0.mem_addr, 14'h010);
    tick();
    check("cf2 c1 mem_addr", bus0.mem_addr, 14'h030);
    tick();
    check("cf2 c2 im_miss",  bus0.im_miss, 1'b0);
    check("cf2 c2 dm_miss",  bus0.dm_miss, 1'b1);
    check("cf2 c2 im_rdata", bus0.im_rdata, 32'h1234_5678);
    bus0.im_ren = 0;
    tick();
    check("cf2 c3 dm_miss",  bus0.dm_miss, 1'b0);
    check("cf2 c3 dm_rdata", bus0.dm_rdata, 32'hCAFE_0030);
    bus0.dm_ren = 0;
    tick();

    // ---- idle ----
    check("idle im_miss", bus0.im_miss, 1'b0);
    check("idle dm_miss", bus0.dm_miss, 1'b0);
    check("idle mem_wen", bus0.mem_wen, 1'b0);
    check("idle mem_ben", bus0.mem_ben, 4'h0);

    // ---- withdrawn write still lands, no second grant ----
    bus0.dm_ben = 4'b1111; bus0.dm_addr = 14'h040; bus0.dm_wdata = 32'h0BAD_F00D; #1;
    check("wd c0 mem_wen", bus0.mem_wen, 1'b1);
    tick();
    bus0.dm_ben = 4'b0; #1;
    check("wd c1 dm_miss", bus0.dm_miss, 1'b0);
    check("wd c1 mem_wen", bus0.mem_wen, 1'b0);
    tick();
    check("wd c2 mem_wen", bus0.mem_wen, 1'b0);
    tick();
    check("wd c3 mem_wen", bus0.mem_wen, 1'b0);
    tick();
    dm_access("wd rd", 4'b0000, 14'h040, 32'h0, 32'h0BAD_F00D);

    // ---- fixed DM priority: dm-only access makes DM the last winner ----
    bus1.dm_ren = 1; bus1.dm_addr = 14'h030; #1;
    check("fx pre c0 mem_addr", bus1.mem_addr, 14'h030);
    tick(); tick();
    check("fx pre c2 dm_rdata", bus1.dm_rdata, 32'hCAFE_0030);
    bus1.dm_ren = 0;
    tick();
    bus1.im_ren = 1; bus1.im_addr = 14'h010;
    bus1.dm_ren = 1; bus1.dm_addr = 14'h050; #1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("fx c%0d mem_addr", c), bus1.mem_addr, fx_addr[c]);
      check($sformatf("fx c%0d dm_miss", c),  bus1.dm_miss,  fx_dm[c]);
      check($sformatf("fx c%0d im_miss", c),  bus1.im_miss,  fx_im[c]);
      if (c == 2) check("fx c2 dm_rdata", bus1.dm_rdata, 32'h5050_A0A0);
      if (c == 3) check("fx c3 im_rdata", bus1.im_rdata, 32'h1234_5678);
      tick();
    end
    bus1.im_ren = 0; bus1.dm_ren = 0;
    tick();

    // ---- reset in the middle of a read ----
    bus0.im_ren = 1; bus0.im_addr = 14'h030; #1;
    check("mr c0 mem_addr", bus0.mem_addr, 14'h030);
    tick();
    reset = 1'b0; #1;
    check("mr rst im_rdata", bus0.im_rdata, 32'h0);
    check("mr rst dm_rdata", bus0.dm_rdata, 32'h0);
    check("mr rst mem_addr", bus0.mem_addr, 14'h0);
    check("mr rst mem_wen",  bus0.mem_wen, 1'b0);
    check("mr rst mem_ben",  bus0.mem_ben, 4'h0);
    check("mr rst im_miss",  bus0.im_miss, 1'b1);
    check("mr rst dm_miss",  bus0.dm_miss, 1'b0);
    tick(); tick();
    check("mr held im_miss",  bus0.im_miss, 1'b1);
    check("mr held im_rdata", bus0.im_rdata, 32'h0);
    reset = 1'b1; #1;
    check("mr rel mem_addr", bus0.mem_addr, 14'h0);
    tick();
    check("mr g0 mem_addr", bus0.mem_addr, 14'h030);
    check("mr g0 im_miss",  bus0.im_miss, 1'b1);
    tick();
    check("mr g1 im_miss",  bus0.im_miss, 1'b1);
    tick();
    check("mr g2 im_miss",  bus0.im_miss, 1'b0);
    check("mr g2 im_rdata", bus0.im_rdata, 32'hCAFE_0030);
    bus0.im_ren = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spram_arbiter
`default_nettype wire
